// File: rtl/tick_prescaler_pkg.sv
`default_nettype none
// ============================================================================
// tick_prescaler_pkg : shared state encoding, mode codes and default sizes
// Rev 1.0
// ============================================================================
package tick_prescaler_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    localparam int DEF_DIV_W       = 8;
    localparam int DEF_BURST_W     = 4;
    localparam int DEF_DEFAULT_DIV = 9;

endpackage
`default_nettype wire

// File: rtl/tick_div_core.sv
`default_nettype none
// ============================================================================
// tick_div_core : prescale counter with terminal compare and hold gating
// Rev 1.0
// ============================================================================
module tick_div_core
    import tick_prescaler_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             hold,
    input  logic [DIV_W-1:0] div_reg,
    output logic             boundary
);

    logic [DIV_W-1:0] pc;
    logic             at_terminal;

    assign at_terminal = (pc == div_reg);
    // Boundary only fires on an edge that actually advances the count.
    assign boundary    = run && !hold && at_terminal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (!run) begin
            pc <= '0;
        end else if (!hold) begin
            if (at_terminal) begin
                pc <= '0;
            end else begin
                pc <= pc + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : run/burst tick strobe generator with divisor reload handshake
// Rev 1.0
// ============================================================================
module tick_prescaler
    import tick_prescaler_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int BURST_W     = DEF_BURST_W,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DIV_W-1:0]   div_in,
    input  logic               div_load,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               div_ack
);

    state_t             state;
    logic               mode_r;
    logic [BURST_W-1:0] blen_r;
    logic [BURST_W-1:0] tick_cnt;
    logic [BURST_W-1:0] tick_cnt_nxt;
    logic [DIV_W-1:0]   div_reg;
    logic               run;
    logic               boundary;
    logic               last_tick;

    // A stop edge clears the prescale count together with the state change.
    assign run          = (state == RUN) && !stop;
    assign tick_cnt_nxt = tick_cnt + BURST_W'(1);
    assign last_tick    = (tick_cnt_nxt == blen_r);

    tick_div_core #(
        .DIV_W    (DIV_W)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .hold     (hold),
        .div_reg  (div_reg),
        .boundary (boundary)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            div_ack  <= 1'b0;
            tick_cnt <= '0;
            mode_r   <= MODE_CONT;
            blen_r   <= '0;
            div_reg  <= DIV_W'(DEFAULT_DIV);
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            div_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_load) begin
                        div_reg <= div_in;
                        div_ack <= 1'b1;
                    end
                    if (start && !stop) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        mode_r   <= mode;
                        blen_r   <= burst_len;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                    end else if (boundary) begin
                        tick <= 1'b1;
                        // Reload lands only between periods so none is cut short.
                        if (div_load) begin
                            div_reg <= div_in;
                            div_ack <= 1'b1;
                        end
                        if (mode_r == MODE_BURST) begin
                            if (last_tick) begin
                                done     <= 1'b1;
                                state    <= IDLE;
                                busy     <= 1'b0;
                                tick_cnt <= '0;
                            end else begin
                                tick_cnt <= tick_cnt_nxt;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_prescaler.sv
`default_nettype none
// ============================================================================
// tb_tick_prescaler : directed self-checking bench for tick_prescaler
// Rev 1.0
// ============================================================================
module tb_tick_prescaler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       hold;
    logic       mode;
    logic [3:0] burst_len;
    logic [7:0] div_in;
    logic       div_load;
    logic       tick;
    logic       busy;
    logic       done;
    logic       div_ack;

    int n_checks = 0;
    int n_pass   = 0;

    logic tlog [0:63];
    logic dlog [0:63];
    logic blog [0:63];
    logic alog [0:63];

    always #5 clk = ~clk;

    tick_prescaler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .mode      (mode),
        .burst_len (burst_len),
        .div_in    (div_in),
        .div_load  (div_load),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .div_ack   (div_ack)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic log_at(input int i);
        tlog[i] = tick;
        dlog[i] = done;
        blog[i] = busy;
        alog[i] = div_ack;
    endtask

    task automatic run_log(input int n);
        for (int i = 1; i <= n; i++) begin
            cycle();
            log_at(i);
        end
    endtask

    // Reload divisor while IDLE; ack must follow one edge later.
    task automatic load_idle(input logic [7:0] d, input string tag);
        div_in   = d;
        div_load = 1'b1;
        cycle();
        check(tag, int'(div_ack), 1);
        div_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int cnt;
        int dcnt;
        logic exp;

        rst = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
        burst_len = 4'd0; div_in = 8'd0; div_load = 1'b0;
        cycle();
        cycle();
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ack",  int'(div_ack), 0);
        rst = 1'b1;

        // Continuous run at the reset divisor 9: ticks every 10 cycles.
        start = 1'b1; mode = 1'b0;
        cycle();
        start = 1'b0;
        check("t1_busy_accept", int'(busy), 1);
        run_log(30);
        bad = 0; cnt = 0; dcnt = 0;
        for (int i = 1; i <= 30; i++) begin
            exp = (i % 10 == 0);
            if (tlog[i] != exp) bad++;
            if (tlog[i]) cnt++;
            if (dlog[i]) dcnt++;
        end
        check("t1_tick_pattern", bad, 0);
        check("t1_tick_count", cnt, 3);
        check("t1_no_done", dcnt, 0);
        check("t1_busy_run", int'(blog[30]), 1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("t1_stop_busy", int'(busy), 0);

        // Burst of 5 at divisor 3.
        load_idle(8'd3, "t2_ack");
        cycle();
        check("t2_ack_one_cycle", int'(div_ack), 0);
        start = 1'b1; mode = 1'b1; burst_len = 4'd5;
        cycle();
        start = 1'b0;
        run_log(25);
        bad = 0; cnt = 0; dcnt = 0;
        for (int i = 1; i <= 25; i++) begin
            exp = (i % 4 == 0) && (i <= 20);
            if (tlog[i] != exp) bad++;
            if (tlog[i]) cnt++;
            if (dlog[i] != (i == 20)) dcnt++;
        end
        check("t2_tick_pattern", bad, 0);
        check("t2_tick_count", cnt, 5);
        check("t2_done_pattern", dcnt, 0);
        check("t2_busy_before_last", int'(blog[19]), 1);
        check("t2_busy_fall", int'(blog[20]), 0);

        // Burst length 0 at divisor 0: 16 back-to-back ticks.
        load_idle(8'd0, "t3_ack");
        start = 1'b1; mode = 1'b1; burst_len = 4'd0;
        cycle();
        start = 1'b0;
        run_log(20);
        bad = 0; cnt = 0; dcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (tlog[i] != (i <= 16)) bad++;
            if (tlog[i]) cnt++;
            if (dlog[i] != (i == 16)) dcnt++;
        end
        check("t3_tick_pattern", bad, 0);
        check("t3_tick_count", cnt, 16);
        check("t3_done_pattern", dcnt, 0);
        check("t3_busy_fall", int'(blog[16]), 0);
        check("t3_busy_15", int'(blog[15]), 1);

        // Mid-period reload from 9 to 1 during a continuous run.
        load_idle(8'd9, "t4_ack_idle");
        start = 1'b1; mode = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            log_at(i);
            if (div_ack) div_load = 1'b0;
            if (i == 3) begin
                div_in   = 8'd1;
                div_load = 1'b1;
            end
        end
        div_load = 1'b0;
        bad = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            exp = (i == 10) || (i > 10 && i % 2 == 0);
            if (tlog[i] != exp) bad++;
            if (alog[i] != (i == 10)) cnt++;
        end
        check("t4_tick_pattern", bad, 0);
        check("t4_ack_pattern", cnt, 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;

        // Hold for 7 edges mid-period freezes the count.
        load_idle(8'd9, "t5_ack_idle");
        start = 1'b1; mode = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            log_at(i);
            if (i == 4)  hold = 1'b1;
            if (i == 11) hold = 1'b0;
        end
        bad = 0;
        for (int i = 1; i <= 30; i++) begin
            if (tlog[i] != (i == 17 || i == 27)) bad++;
        end
        check("t5_tick_pattern", bad, 0);
        check("t5_tick_17", int'(tlog[17]), 1);
        stop = 1'b1; start = 1'b1;
        cycle();
        stop = 1'b0; start = 1'b0;
        check("t5_stop_busy", int'(busy), 0);
        check("t5_stop_tick", int'(tick), 0);
        check("t5_stop_done", int'(done), 0);
        cycle();
        check("t5_idle_busy", int'(busy), 0);

        // Reset asserted during the third tick of an 8-tick burst at divisor 4.
        load_idle(8'd4, "t6_ack_idle");
        start = 1'b1; mode = 1'b1; burst_len = 4'd8;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 15; i++) cycle();
        check("t6_third_tick", int'(tick), 1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("t6_rst_tick", int'(tick), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        check("t6_rst_ack",  int'(div_ack), 0);
        run_log(20);
        dcnt = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (dlog[i]) dcnt++;
            if (tlog[i] || blog[i]) cnt++;
        end
        check("t6_no_done_after_rst", dcnt, 0);
        check("t6_quiet_after_rst", cnt, 0);
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check("t6_start_stop_idle", int'(busy), 0);
        cycle();
        check("t6_still_idle", int'(busy), 0);
        // Reset must have restored the default divisor of 9.
        start = 1'b1; mode = 1'b0;
        cycle();
        start = 1'b0;
        run_log(12);
        bad = 0;
        for (int i = 1; i <= 12; i++) begin
            if (tlog[i] != (i == 10)) bad++;
        end
        check("t6_default_div", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_prescaler.md
Name: tick_prescaler

Overview:
Programmable tick generator that produces the single-cycle enable strobe consumed by the 4-bit synchronous up-counter's en input. It sits directly upstream of that counter and turns the fast system clock into a slower, controllable count rate. It supports continuous or fixed-length burst operation, run/pause/stop control, and a handshaked divisor reload.

Parameters:
DIV_W, 8, width of divisor and prescale counter
BURST_W, 4, width of burst length and tick counter
DEFAULT_DIV, 9, divisor loaded at reset (tick period = DEFAULT_DIV+1 cycles)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
start  in  1  level, sampled in IDLE; begins operation
stop  in  1  level; abort to IDLE, highest priority after reset
hold  in  1  level; pause prescaling while RUN
mode  in  1  0 = continuous, 1 = burst; latched on start
burst_len  in  BURST_W  ticks per burst; latched on start; 0 means 2^BURST_W
div_in  in  DIV_W  new divisor; stable while div_load high
div_load  in  1  divisor reload request, held until div_ack
tick  out  1  one-cycle enable strobe to counter en
busy  out  1  high while state = RUN
done  out  1  one-cycle pulse on burst completion
div_ack  out  1  one-cycle acceptance of div_load

Behaviour:
- All state updates occur on rising clk only. rst=0 at an edge forces: state IDLE, pc=0, tick_cnt=0, div_reg=DEFAULT_DIV, tick=0, done=0, div_ack=0, busy=0. Applies equally mid-burst; no done is issued.
- All outputs are registered. busy is decoded from the state register.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 and stop=0 -> RUN; pc<=0, tick_cnt<=0; mode_r and blen_r latched from mode and burst_len.
  - start and stop together -> remain IDLE.
- RUN, priority stop > hold > count:
  - stop=1 -> IDLE, tick<=0, done<=0, pc and tick_cnt cleared.
  - hold=1 -> pc frozen, tick<=0.
  - Otherwise:
    - pc==div_reg: pc<=0, tick<=1.
    - Else pc<=pc+1, tick<=0.
- Timing: first tick is high in the cycle after edge k+div_reg+1, where k is the start-accept edge. Period is div_reg+1 cycles. div_reg=0 gives tick every cycle.
- Burst mode:
  - Each issued tick increments tick_cnt, modulo 2^BURST_W.
  - On the edge issuing the tick for which (tick_cnt+1) mod 2^BURST_W == blen_r: tick<=1, done<=1, state<=IDLE. tick and done are therefore coincident.
  - blen_r=0 yields 2^BURST_W ticks.
- Continuous mode: tick_cnt held at 0; runs until stop.
- Divisor reload handshake:
  - In IDLE: div_load=1 -> div_reg<=div_in and div_ack<=1 on the next edge.
  - In RUN: accepted only on a period-boundary edge (pc==div_reg, hold=0). The new div_reg governs the following period. The current period is never truncated.
  - div_ack is high for exactly one cycle per request. The requester must drop div_load in the cycle after div_ack. A still-high div_load is treated as a new request.
  - div_load during hold is deferred to the next boundary.
  - Reload and stop on the same edge: stop wins; the request is accepted on the next edge in IDLE.
- No combinational path from inputs to outputs.

Decomposition:
- Package tick_prescaler_pkg: state enum (IDLE, RUN), mode constants MODE_CONT=0 and MODE_BURST=1, default parameter values.
- One natural sub-module, tick_div_core: pc register, terminal compare, and hold gating. It outputs a boundary pulse to the FSM.
- The FSM, burst counter and reload handshake stay in the top.

Test Plan:
1. Reset then start=1 for 1 cycle, mode=0, default div 9 -> first tick 10 cycles after the accept edge, then every 10 cycles; busy=1; done never asserts.
2. div_load=1 with div_in=3 in IDLE -> div_ack after 1 edge; then start with mode=1, burst_len=5 -> exactly 5 ticks spaced 4 cycles; done coincides with the 5th tick; busy falls on the same edge.
3. Burst with burst_len=0 and div=0 -> 16 consecutive tick cycles, done on the 16th, back to IDLE.
4. Continuous run at div=9; div_load with div_in=1 mid-period -> div_ack on the next boundary; the current 10-cycle period completes, then tick every 2 cycles.
5. Continuous run; hold=1 for 7 cycles mid-period -> no ticks, pc frozen; the period resumes with the remaining count. Then stop=1 with start=1 -> IDLE, tick=0, no done.
6. rst=0 for one edge during the 3rd tick of a burst_len=8 run -> all outputs 0, div_reg=9, no done. Start+stop in the same cycle afterwards -> stays IDLE.
